// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: command bytes, error ack and FSM state type shared by the debug bridge.
package uart_dbg_pkg;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] ACK_ERR  = 8'h3F;
    typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_TERM, ST_REPLY} state_e;
endpackage

// File: rtl/uart_dbg_bridge_if.sv
// uart_dbg_bridge_if: UART receive byte input and TX char FIFO write port of the debug bridge.
//   rx_data/rx_data_rdy : received byte and its ready level (rising edge = new byte)
//   fifo_full           : TX FIFO full
//   fifo_din/fifo_wr_en : byte and write strobe into the TX FIFO
//   master = bridge side, slave = UART/FIFO side
interface uart_dbg_bridge_if;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       fifo_full;
    logic [7:0] fifo_din;
    logic       fifo_wr_en;
    modport master (input rx_data, rx_data_rdy, fifo_full, output fifo_din, fifo_wr_en);
    modport slave (output rx_data, rx_data_rdy, fifo_full, input fifo_din, fifo_wr_en);
endinterface

// File: rtl/uart_dbg_hex.sv
// uart_dbg_hex: 4-bit value to uppercase ASCII hex digit.
//   nib   : value 0..15
//   ascii : '0'..'9' or 'A'..'F'
module uart_dbg_hex (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);
    assign ascii = nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
endmodule

// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: command-driven debug bridge from UART RX bytes to the TX char FIFO.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : uart_dbg_bridge_if.master (rx byte in, FIFO write port out)
//   dbg_words : debug bank, word k at [k*WORD_W +: WORD_W]
//   run, step : pipeline free-run enable and single-cycle step pulse
//   busy      : dump or reply pending
//   err_drop  : sticky, a command arrived while busy
// Define UART_DBG_HEX_EN to send each snapshot byte as two ASCII hex digits.
module uart_dbg_bridge
    import uart_dbg_pkg::*;
#(
    parameter int         NUM_WORDS = 8,
    parameter int         WORD_W    = 32,
    parameter logic [7:0] TERM_BYTE = 8'h0A
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_dbg_bridge_if.master           bus,
    input  logic [NUM_WORDS*WORD_W-1:0] dbg_words,
    output logic                        run,
    output logic                        step,
    output logic                        busy,
    output logic                        err_drop
);
    localparam int BPW = WORD_W / 8;
    localparam int NB  = NUM_WORDS * BPW;
    localparam int IW  = NB > 1 ? $clog2(NB) : 1;
    state_e        state;
    logic          rdy_q, cmd_stb, unit_last;
    logic [IW-1:0] idx;
    logic [7:0]    ack, cur_byte, unit_byte;
    // Snapshot kept in transmit order: byte i is the i-th byte on the wire.
    logic [7:0]    snap [NB];
    assign cmd_stb = bus.rx_data_rdy & ~rdy_q;
    assign busy = state != ST_IDLE;
    assign bus.fifo_wr_en = busy & ~bus.fifo_full & ~rst;
    assign cur_byte = snap[idx];
    assign bus.fifo_din = state == ST_DUMP ? unit_byte :
                          state == ST_TERM ? TERM_BYTE :
                          state == ST_REPLY ? ack : 8'h00;
`ifdef UART_DBG_HEX_EN
    logic nib;
    uart_dbg_hex u_hex (.nib(nib ? cur_byte[3:0] : cur_byte[7:4]), .ascii(unit_byte));
    assign unit_last = nib;
    always_ff @(posedge clk)
        if (rst || state != ST_DUMP) nib <= 1'b0;
        else if (bus.fifo_wr_en) nib <= ~nib;
`else
    assign unit_byte = cur_byte;
    assign unit_last = 1'b1;
`endif
    always_ff @(posedge clk)
        if (!rst && state == ST_IDLE && cmd_stb && bus.rx_data == CMD_DUMP)
            for (int i = 0; i < NB; i++)
                snap[i] <= dbg_words[(i / BPW) * WORD_W + (BPW - 1 - i % BPW) * 8 +: 8];
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rdy_q    <= 1'b0;
            run      <= 1'b0;
            step     <= 1'b0;
            err_drop <= 1'b0;
            idx      <= '0;
            ack      <= 8'h00;
        end else begin
            rdy_q <= bus.rx_data_rdy;
            step  <= 1'b0;
            if (cmd_stb && busy) err_drop <= 1'b1;
            case (state)
                ST_IDLE: if (cmd_stb) begin
                    idx   <= '0;
                    state <= bus.rx_data == CMD_DUMP ? ST_DUMP : ST_REPLY;
                    run   <= bus.rx_data == CMD_RUN ? 1'b1 : bus.rx_data == CMD_HALT ? 1'b0 : run;
                    step  <= bus.rx_data == CMD_STEP && !run;
                    ack   <= (bus.rx_data == CMD_RUN || bus.rx_data == CMD_HALT ||
                              (bus.rx_data == CMD_STEP && !run)) ? bus.rx_data : ACK_ERR;
                end
                ST_DUMP: if (bus.fifo_wr_en && unit_last) begin
                    if (idx == IW'(NB - 1)) state <= ST_TERM;
                    else idx <= idx + 1'b1;
                end
                default: if (bus.fifo_wr_en) state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb_uart_dbg_bridge: directed scoreboard bench for uart_dbg_bridge (2 x 32-bit words).
module tb_uart_dbg_bridge;
    localparam int NW = 2;
    localparam int WW = 32;
`ifdef UART_DBG_HEX_EN
    localparam int UPB = 2;
`else
    localparam int UPB = 1;
`endif
    localparam int DUMP_LEN = NW * WW / 8 * UPB + 1;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NW*WW-1:0] dbg_words;
    logic           run, step, busy, err_drop;
    int             tests = 0;
    int             fails = 0;
    logic [7:0]     exp_q[$];
    uart_dbg_bridge_if bus();
    uart_dbg_bridge #(.NUM_WORDS(NW), .WORD_W(WW), .TERM_BYTE(8'h0A)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_words(dbg_words),
        .run(run), .step(step), .busy(busy), .err_drop(err_drop)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] hexc(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
    endfunction
    task automatic push_dump();
        logic [31:0] w [2];
        logic [7:0]  by;
        w[0] = 32'h12345678;
        w[1] = 32'hDEADBEEF;
        for (int k = 0; k < 2; k++)
            for (int b = 3; b >= 0; b--) begin
                by = w[k][b*8 +: 8];
`ifdef UART_DBG_HEX_EN
                exp_q.push_back(hexc(by[7:4]));
                exp_q.push_back(hexc(by[3:0]));
`else
                exp_q.push_back(by);
`endif
            end
        exp_q.push_back(8'h0A);
    endtask
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        bus.rx_data = c;
        bus.rx_data_rdy = 1'b1;
        @(negedge clk);
        bus.rx_data_rdy = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask
    always @(negedge clk) begin
        if (rst) chk("wr_in_reset", {31'd0, bus.fifo_wr_en}, 0);
        else if (bus.fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_write: observed %h expected no write", bus.fifo_din);
            end else chk("fifo_din", {24'd0, bus.fifo_din}, {24'd0, exp_q.pop_front()});
        end
    end
    initial begin
        bus.rx_data = 8'h00;
        bus.rx_data_rdy = 1'b0;
        bus.fifo_full = 1'b0;
        dbg_words = {32'hDEADBEEF, 32'h12345678};
        @(negedge clk);
        bus.rx_data = 8'h44;
        bus.rx_data_rdy = 1'b1;
        @(negedge clk);
        bus.rx_data_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wr_en", {31'd0, bus.fifo_wr_en}, 0);
        chk("rst_din", {24'd0, bus.fifo_din}, 0);
        chk("rst_run", {31'd0, run}, 0);
        chk("rst_step", {31'd0, step}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err_drop", {31'd0, err_drop}, 0);
        // Gapless dump; dbg_words is cleared right after the strobe to prove the snapshot froze.
        push_dump();
        send(8'h44);
        dbg_words = '0;
        for (int i = 0; i < DUMP_LEN; i++) begin
            chk("dump_gapless", {31'd0, bus.fifo_wr_en}, 1);
            chk("dump_busy", {31'd0, busy}, 1);
            @(negedge clk);
        end
        chk("dump_end_busy", {31'd0, busy}, 0);
        chk("dump_end_wr", {31'd0, bus.fifo_wr_en}, 0);
        chk("dump_queue", exp_q.size(), 0);
        dbg_words = {32'hDEADBEEF, 32'h12345678};
        // Back-pressure for 3 cycles after the 3rd unit.
        push_dump();
        send(8'h44);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_no_wr", {31'd0, bus.fifo_wr_en}, 0);
            chk("stall_hold_din", {24'd0, bus.fifo_din}, {24'd0, exp_q[0]});
        end
        @(posedge clk);
        #1 bus.fifo_full = 1'b0;
        wait_idle();
        // Control commands.
        exp_q.push_back(8'h53);
        send(8'h53);
        chk("step_pulse", {31'd0, step}, 1);
        @(negedge clk);
        chk("step_once", {31'd0, step}, 0);
        wait_idle();
        exp_q.push_back(8'h52);
        send(8'h52);
        wait_idle();
        chk("run_set", {31'd0, run}, 1);
        exp_q.push_back(8'h3F);
        send(8'h53);
        chk("step_blocked", {31'd0, step}, 0);
        wait_idle();
        chk("run_kept", {31'd0, run}, 1);
        exp_q.push_back(8'h48);
        send(8'h48);
        wait_idle();
        chk("run_clear", {31'd0, run}, 0);
        exp_q.push_back(8'h3F);
        send(8'h7A);
        wait_idle();
        chk("err_drop_clean", {31'd0, err_drop}, 0);
        // Command during a dump, then reset at the 5th unit.
        push_dump();
        send(8'h44);
        send(8'h52);
        chk("overlap_err_drop", {31'd0, err_drop}, 1);
        chk("overlap_run", {31'd0, run}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_units_left", exp_q.size(), DUMP_LEN - 4);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_err_drop", {31'd0, err_drop}, 0);
        chk("post_rst_run", {31'd0, run}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_wr", {31'd0, bus.fifo_wr_en}, 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

Command-driven debug bridge between the UART receiver's byte output and the transmit character FIFO's write port. It decodes single-byte commands from the host. It snapshots a parametrised bank of debug words from the pipeline and streams them back as raw or ASCII-hex bytes. It also owns the pipeline's run/step control, replacing the fixed one-byte-per-receive echo path with a general, flow-controlled dump engine.

## Interface
- NUM_WORDS, 8, number of debug words in the snapshot (≥1)
- WORD_W, 32, bits per debug word; must be a multiple of 8
- TERM_BYTE, 8'h0A, byte appended after every dump

- clk  in  1  system clock; all logic is on its rising edge
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received byte from the UART receiver
- rx_data_rdy  in  1  receiver ready level; its rising edge marks a new byte
- dbg_words  in  NUM_WORDS*WORD_W  debug bank; word k is at bits [k*WORD_W +: WORD_W]
- fifo_full  in  1  TX char FIFO full
- fifo_din  out  8  byte to the FIFO
- fifo_wr_en  out  1  FIFO write strobe; the byte is written on the edge where it is high
- run  out  1  pipeline free-run enable
- step  out  1  single-cycle pipeline step pulse
- busy  out  1  high while a dump or reply is pending
- err_drop  out  1  sticky flag: a command arrived while busy

## Operation
- rdy_q registers rx_data_rdy. cmd_stb = rx_data_rdy & ~rdy_q; the command is rx_data in that same cycle.
- FSM states are IDLE, DUMP, TERM, REPLY. cmd_stb is acted on only in IDLE.
- Command 0x44 'D': on the strobe edge, load snap ← dbg_words, clear the byte/nibble index, and go to DUMP.
- Command 0x52 'R': set run=1. Go to REPLY with ack=0x52.
- Command 0x48 'H': clear run=0. Go to REPLY with ack=0x48.
- Command 0x53 'S' with run=0: step=1 for exactly one cycle, starting the cycle after the strobe. Go to REPLY with ack=0x53.
- Command 0x53 'S' with run=1: no step. Go to REPLY with ack=0x3F.
- Any other byte: go to REPLY with ack=0x3F ('?').
- DUMP sends words 0..NUM_WORDS-1 in order, most significant byte first. After the last unit it goes to TERM.
- TERM sends TERM_BYTE, then goes to IDLE.
- REPLY sends ack, then goes to IDLE.
- fifo_wr_en = (state ∈ {DUMP, TERM, REPLY}) & ~fifo_full & ~rst. This is combinational, so the FIFO can never be overflowed.
- fifo_din is combinational from state, snap and index. The index advances only on edges where fifo_wr_en=1.
- busy = (state ≠ IDLE).
- A cmd_stb while busy is discarded and sets err_drop=1. err_drop is cleared only by rst.
- The snapshot is frozen for the whole dump; changes on dbg_words after the strobe are not reflected.

## Timing
- Reset values: fifo_wr_en=0, fifo_din=0, run=0, step=0, busy=0, err_drop=0; state=IDLE; rdy_q=0.
- Strobe in cycle N. The first fifo_wr_en can be high in cycle N+1.
- With fifo_full=0 the block writes one byte per cycle with no gaps.
- Dump length is NUM_WORDS*WORD_W/8 bytes (raw) or twice that (hex), plus 1 for TERM_BYTE.
- fifo_full=1 stalls the index. The same byte is held on fifo_din, so no byte is lost or duplicated.
- rst mid-dump: fifo_wr_en is 0 in the rst cycle and the FSM is in IDLE afterwards. There is no terminator and no partial-byte completion. run clears.
- The index wraps only via a state transition; there is no modular wrap inside DUMP.

## Configuration
- UART_DBG_HEX_EN defined: each snapshot byte is sent as two ASCII hex characters, upper nibble first. Digits are 0x30–0x39 and uppercase 0x41–0x46. TERM_BYTE and ack bytes are unaffected.
- UART_DBG_HEX_EN undefined: snapshot bytes are sent raw, and the nibble counter is not built.

## Structure
- Package uart_dbg_pkg holds:
  - command constants CMD_DUMP, CMD_RUN, CMD_HALT, CMD_STEP
  - ACK_ERR = 8'h3F
  - the FSM state enum
- One sub-module, uart_dbg_hex: a 4-bit to ASCII-hex encoder. It is instantiated only under UART_DBG_HEX_EN.
- Index width is $clog2(NUM_WORDS*WORD_W/8) plus 1 nibble bit in hex mode.

## Test plan
All cases use NUM_WORDS=2, WORD_W=32, word0=0x12345678, word1=0xDEADBEEF.
- Reset: hold rst for 2 cycles → all outputs 0; rx_data_rdy toggling during rst produces no writes.
- Raw dump: send 'D' with fifo_full=0 → bytes 12 34 56 78 DE AD BE EF 0A on 9 consecutive cycles starting at strobe+1; busy falls after the last write.
- Hex dump (UART_DBG_HEX_EN): send 'D' → "12345678DEADBEEF" (0x31 0x32 … 0x45 0x46) then 0x0A, 17 writes.
- Back-pressure: force fifo_full=1 for 3 cycles after the 3rd byte → no writes during those cycles; the sequence resumes with 0x78 and all 9 bytes arrive exactly once.
- Control:
  - 'S' with run=0 → step high for exactly 1 cycle, ack 0x53.
  - 'R' → run=1, ack 0x52.
  - 'S' → no step, ack 0x3F.
  - 'H' → run=0, ack 0x48.
  - 0x7A → ack 0x3F.
- Overlap and reset: send 'R' during a dump → ignored, err_drop=1, dump bytes unchanged, run unchanged. Assert rst at the 5th byte → no further writes, FSM in IDLE, err_drop=0.
